// File: rtl/knn_buf_pkg.sv
// Shared constants, op encoding and FSM state type for the local search-point buffer.
package knn_buf_pkg;

   localparam int DATA_W = 256;
   localparam int DEPTH  = 2048;
   localparam int ADDR_W = 11;

   localparam logic OP_LOAD = 1'b0;
   localparam logic OP_SCAN = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      DRAIN,
      FIN
   } state_e;

endpackage

// File: rtl/knn_sync_fifo.sv
// Small first-word-fall-through FIFO with occupancy count; catches buffer read data.
module knn_sync_fifo #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   // Pointer advance with wrap at an arbitrary (non power of two) depth.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   // Next pointers and count; push+pop together leaves the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage: contents need no reset, validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/knn_local_sp_buf_ctrl.sv
// Owns the single port of one local search-point buffer: LOAD writes a stream in,
// SCAN reads it back out through a credit-controlled FIFO under backpressure.
module knn_local_sp_buf_ctrl
   import knn_buf_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic              op,
   input  logic [ADDR_W:0]   num_words,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [ADDR_W-1:0] mem_address0,
   output logic              mem_ce0,
   output logic              mem_we0,
   output logic [DATA_W-1:0] mem_d0,
   input  logic [DATA_W-1:0] mem_q0
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CW    = ADDR_W + 1;

   state_e                  state_q, state_d;
   logic [CW-1:0]           n_q, n_d;
   logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]           pop_cnt_q, pop_cnt_d;
   logic [ADDR_W-1:0]       last_addr_q, last_addr_d;
   logic [READ_LATENCY-1:0] tag_q, tag_d;

   logic [CW-1:0]     n_clamped;
   logic [CNT_W-1:0]  inflight, fifo_count;
   logic [CNT_W:0]    credit_used;
   logic              wr_fire, rd_fire, fifo_push, fifo_pop, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   assign n_clamped   = (num_words > CW'(DEPTH)) ? CW'(DEPTH) : num_words;
   assign inflight    = CNT_W'($countones(tag_q));
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
   assign wr_fire     = (state_q == LOAD) && s_tvalid;
   // A read may only issue if its data is guaranteed a FIFO slot on arrival.
   assign rd_fire     = (state_q == SCAN) && (rd_cnt_q < n_q) &&
                        (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign fifo_push   = tag_q[READ_LATENCY-1];
   assign fifo_pop    = !fifo_empty && m_tready;

   // Issue tags travel alongside the memory pipeline so only real reads are captured.
   generate
      if (READ_LATENCY == 1) begin : g_tag1
         assign tag_d = rd_fire;
      end else begin : g_tagn
         assign tag_d = {tag_q[READ_LATENCY-2:0], rd_fire};
      end
   endgenerate

   // Next-state logic and counter updates.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      pop_cnt_d   = pop_cnt_q;
      last_addr_d = last_addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               n_d         = n_clamped;
               wr_cnt_d    = '0;
               rd_cnt_d    = '0;
               pop_cnt_d   = '0;
               last_addr_d = '0;
               if (n_clamped == '0)   state_d = FIN;
               else if (op == OP_SCAN) state_d = SCAN;
               else                    state_d = LOAD;
            end
         end
         LOAD: begin
            if (wr_fire) begin
               wr_cnt_d = wr_cnt_q + CW'(1);
               if (wr_cnt_q + CW'(1) == n_q) state_d = FIN;
            end
         end
         SCAN: begin
            if (rd_fire) begin
               rd_cnt_d    = rd_cnt_q + CW'(1);
               last_addr_d = rd_cnt_q[ADDR_W-1:0];
               if (rd_cnt_q + CW'(1) == n_q) state_d = DRAIN;
            end
            if (fifo_pop) pop_cnt_d = pop_cnt_q + CW'(1);
         end
         DRAIN: begin
            if (fifo_pop) pop_cnt_d = pop_cnt_q + CW'(1);
            if ((fifo_count == '0) && (tag_q == '0)) state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; idle values are all zero so reset clears every output at once.
   always_comb begin
      busy         = (state_q != IDLE);
      done         = (state_q == FIN);
      s_tready     = (state_q == LOAD);
      mem_ce0      = 1'b0;
      mem_we0      = wr_fire;
      mem_address0 = '0;
      mem_d0       = wr_fire ? s_tdata : '0;
      case (state_q)
         LOAD: begin
            mem_ce0      = wr_fire;
            mem_address0 = wr_fire ? wr_cnt_q[ADDR_W-1:0] : '0;
         end
         SCAN: begin
            mem_ce0      = 1'b1;
            mem_address0 = rd_fire ? rd_cnt_q[ADDR_W-1:0] : last_addr_q;
         end
         DRAIN: begin
            mem_ce0      = 1'b1;
            mem_address0 = last_addr_q;
         end
         default: ;
      endcase
      m_tvalid = !fifo_empty;
      m_tdata  = fifo_empty ? '0 : fifo_head;
      m_tlast  = !fifo_empty && (pop_cnt_q == n_q - CW'(1));
   end

   // State, counters and issue tags.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         n_q         <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         pop_cnt_q   <= '0;
         last_addr_q <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         last_addr_q <= last_addr_d;
         tag_q       <= tag_d;
      end
   end

   knn_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .push_i  (fifo_push),
      .data_i  (mem_q0),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_knn_local_sp_buf_ctrl.sv
// Bench: three controllers (read latency 1, 2, 4) share one command/stream stimulus;
// each owns a behavioural buffer model and is checked against a flat reference array.
module tb_knn_local_sp_buf_ctrl;
   import knn_buf_pkg::*;

   localparam int NI = 3;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b1;
   logic              start = 1'b0;
   logic              op = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic [DATA_W-1:0] s_tdata = '0;
   logic              s_tvalid = 1'b0;
   logic              m_tready = 1'b0;

   logic [NI-1:0]     busy_w, done_w, s_tready_w, m_tvalid_w, m_tlast_w, mem_ce_w, mem_we_w;
   logic [ADDR_W-1:0] mem_addr_w [NI];
   logic [DATA_W-1:0] mem_d_w    [NI];
   logic [DATA_W-1:0] m_tdata_w  [NI];

   always #5 ap_clk = ~ap_clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int RL = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
      logic [DATA_W-1:0] ram  [DEPTH];
      logic [DATA_W-1:0] pipe [RL];

      knn_local_sp_buf_ctrl #(.READ_LATENCY(RL)) dut (
         .ap_clk       (ap_clk),
         .ap_rst_n     (ap_rst_n),
         .start        (start),
         .op           (op),
         .num_words    (num_words),
         .busy         (busy_w[gi]),
         .done         (done_w[gi]),
         .s_tdata      (s_tdata),
         .s_tvalid     (s_tvalid),
         .s_tready     (s_tready_w[gi]),
         .m_tdata      (m_tdata_w[gi]),
         .m_tvalid     (m_tvalid_w[gi]),
         .m_tready     (m_tready),
         .m_tlast      (m_tlast_w[gi]),
         .mem_address0 (mem_addr_w[gi]),
         .mem_ce0      (mem_ce_w[gi]),
         .mem_we0      (mem_we_w[gi]),
         .mem_d0       (mem_d_w[gi]),
         .mem_q0       (pipe[RL-1])
      );

      // Buffer model: pipelined read of RL stages, advancing only while enabled.
      always @(posedge ap_clk) begin
         if (mem_ce_w[gi]) begin
            if (mem_we_w[gi]) ram[mem_addr_w[gi]] <= mem_d_w[gi];
            pipe[0] <= ram[mem_addr_w[gi]];
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
         end
      end
   end

   // Reference state
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int          n_checks = 0, n_err = 0;
   int          edge_cnt = 0, start_edge = 0;
   int          neff = 0, load_idx = 0;
   logic        cur_op = OP_LOAD;
   bit          op_active = 0, is_n0 = 0, b2b_chk = 0, prev_ready = 0;
   int          rd_idx [NI], done_cnt [NI], done_edge [NI], first_valid [NI], last_beat [NI];
   bit          finished [NI], prev_valid [NI];
   logic [DATA_W-1:0] prev_data [NI];

   function automatic int rl_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all instances against the reference for the current cycle (called mid-cycle).
   task automatic sample();
      logic exp_wr;
      exp_wr = op_active && (cur_op == OP_LOAD) && s_tvalid && (load_idx < neff);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("busy%0d", i), busy_w[i], op_active && !finished[i]);
         check($sformatf("s_tready%0d", i), s_tready_w[i],
               op_active && (cur_op == OP_LOAD) && (load_idx < neff));
         check($sformatf("mem_we%0d", i), mem_we_w[i], exp_wr);
         if (cur_op == OP_LOAD || is_n0 || !op_active)
            check($sformatf("mem_ce%0d", i), mem_ce_w[i], exp_wr);
         else if (rd_idx[i] < neff)
            check($sformatf("mem_ce_scan%0d", i), mem_ce_w[i], 1'b1);
         if (exp_wr) begin
            check($sformatf("wr_addr%0d", i), mem_addr_w[i], load_idx[ADDR_W-1:0]);
            check($sformatf("wr_data%0d", i), mem_d_w[i], s_tdata);
         end
         if (prev_valid[i] && !prev_ready) begin
            check($sformatf("stall_valid%0d", i), m_tvalid_w[i], 1'b1);
            check($sformatf("stall_data%0d", i), m_tdata_w[i], prev_data[i]);
         end
         if (m_tvalid_w[i] && op_active && cur_op == OP_SCAN && first_valid[i] < 0)
            first_valid[i] = edge_cnt - start_edge;
         if (m_tvalid_w[i] && m_tready) begin
            check($sformatf("beat_expected%0d", i),
                  op_active && (cur_op == OP_SCAN) && (rd_idx[i] < neff), 1'b1);
            if (rd_idx[i] < neff) begin
               check($sformatf("beat_data%0d_w%0d", i, rd_idx[i]), m_tdata_w[i], ref_mem[rd_idx[i]]);
               check($sformatf("beat_last%0d_w%0d", i, rd_idx[i]), m_tlast_w[i], rd_idx[i] == neff - 1);
            end
            if (b2b_chk && rd_idx[i] > 0)
               check($sformatf("back_to_back%0d", i), edge_cnt, last_beat[i] + 1);
            last_beat[i] = edge_cnt;
            rd_idx[i]++;
         end
         if (done_w[i]) begin
            done_cnt[i]++;
            done_edge[i] = edge_cnt - start_edge;
            if (cur_op == OP_LOAD) check($sformatf("done_after_writes%0d", i), load_idx, neff);
            else                   check($sformatf("done_after_beats%0d", i), rd_idx[i], neff);
            finished[i] = 1;
         end
         prev_valid[i] = m_tvalid_w[i];
         prev_data[i]  = m_tdata_w[i];
      end
      prev_ready = m_tready;
      if (exp_wr) begin
         ref_mem[load_idx] = s_tdata;
         load_idx++;
      end
   endtask

   task automatic tick();
      @(negedge ap_clk);
      sample();
      @(posedge ap_clk);
      edge_cnt++;
      #1;
   endtask

   function automatic bit all_finished();
      bit r = 1;
      for (int i = 0; i < NI; i++) r &= finished[i];
      return r;
   endfunction

   task automatic begin_op(input logic o, input int n);
      neff = (n > DEPTH) ? DEPTH : n;
      cur_op = o; is_n0 = (neff == 0); load_idx = 0;
      for (int i = 0; i < NI; i++) begin
         rd_idx[i] = 0; done_cnt[i] = 0; done_edge[i] = -1; first_valid[i] = -1;
         last_beat[i] = 0; finished[i] = 0;
      end
      start = 1'b1; op = o; num_words = (ADDR_W + 1)'(n);
      s_tvalid = 1'b0; m_tready = 1'b0;
      tick();
      start_edge = edge_cnt;
      start = 1'b0;
      op_active = 1;
   endtask

   // mode: 0 full rate, 1 random, 2 ready pattern 1-0-0-1, 3 valid every other cycle, 4 data 0xA0+i
   task automatic step(input int mode, input int cyc);
      start = (neff >= 8) && (cyc == 2);   // stray strobe while busy must be ignored
      op = ~cur_op;
      num_words = (ADDR_W + 1)'(5);
      if (cur_op == OP_LOAD) begin
         case (mode)
            1:       s_tvalid = 1'($urandom_range(0, 1));
            3:       s_tvalid = (cyc % 2 == 0);
            default: s_tvalid = 1'b1;
         endcase
         if (mode == 4) s_tdata = DATA_W'(32'hA0 + load_idx);
         else for (int k = 0; k < DATA_W / 32; k++) s_tdata[k*32 +: 32] = $urandom();
      end else begin
         case (mode)
            1:       m_tready = ($urandom_range(0, 3) != 0);
            2:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_tready = 1'b1;
         endcase
      end
   endtask

   task automatic end_op(input int budget_left_ok);
      check("op_within_budget", all_finished(), 1'b1);
      if (budget_left_ok == 0) begin end
      s_tvalid = 1'b0; m_tready = 1'b0; start = 1'b0;
      op_active = 0;
      tick(); tick();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("done_pulses%0d", i), done_cnt[i], 1);
         if (cur_op == OP_SCAN) begin
            check($sformatf("scan_words%0d", i), rd_idx[i], neff);
            if (neff > 0) check($sformatf("first_valid_lat%0d", i), first_valid[i], rl_of(i) + 1);
         end
         if (is_n0) check($sformatf("n0_done_latency%0d", i), done_edge[i] <= 1, 1'b1);
      end
      if (cur_op == OP_LOAD) check("load_words", load_idx, neff);
   endtask

   task automatic run_op(input logic o, input int n, input int mode, input int budget);
      int cyc = 0;
      begin_op(o, n);
      while (!all_finished() && cyc < budget) begin
         step(mode, cyc);
         tick();
         cyc++;
      end
      end_op(budget - cyc);
   endtask

   initial begin
      int cyc;
      // Reset state
      #2 ap_rst_n = 1'b0;
      #1;
      check("rst_ctrl", {busy_w, done_w, s_tready_w, m_tvalid_w, m_tlast_w, mem_ce_w, mem_we_w}, '0);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_addr%0d", i), mem_addr_w[i], '0);
         check($sformatf("rst_d%0d", i), mem_d_w[i], '0);
         check($sformatf("rst_tdata%0d", i), m_tdata_w[i], '0);
      end
      tick(); tick();
      ap_rst_n = 1'b1;
      tick();

      // Load then scan, full rate
      run_op(OP_LOAD, 4, 4, 50);
      b2b_chk = 1;
      run_op(OP_SCAN, 4, 0, 50);
      b2b_chk = 0;

      // Upstream gaps, then random gaps and patterned backpressure
      run_op(OP_LOAD, 8, 3, 60);
      run_op(OP_LOAD, 16, 1, 200);
      run_op(OP_SCAN, 16, 2, 300);

      // Zero-length commands
      run_op(OP_LOAD, 0, 0, 10);
      run_op(OP_SCAN, 0, 0, 10);

      // Full depth and clamped counts
      run_op(OP_LOAD, 3000, 0, 2300);
      check("clamp_last_write_addr", load_idx - 1, DEPTH - 1);
      run_op(OP_SCAN, 2048, 1, 6000);
      run_op(OP_SCAN, 3000, 0, 2300);

      // Reset in the middle of a scan
      begin_op(OP_SCAN, 10);
      cyc = 0;
      while (rd_idx[0] < 5 && cyc < 100) begin
         step(0, cyc);
         tick();
         cyc++;
      end
      check("reached_word5", rd_idx[0] >= 5, 1'b1);
      ap_rst_n = 1'b0;
      op_active = 0;
      #1;
      check("abort_ctrl", {busy_w, done_w, s_tready_w, m_tvalid_w, m_tlast_w, mem_ce_w, mem_we_w}, '0);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("abort_addr%0d", i), mem_addr_w[i], '0);
         check($sformatf("abort_tdata%0d", i), m_tdata_w[i], '0);
         prev_valid[i] = 0;
      end
      m_tready = 1'b0;
      tick(); tick();
      ap_rst_n = 1'b1;
      tick(); tick();
      for (int i = 0; i < NI; i++) check($sformatf("abort_no_done%0d", i), done_cnt[i], 0);
      run_op(OP_SCAN, 3, 0, 50);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
